icetap_jtag_master: RTL and testbench

// On-chip JTAG initiator: drives TCK/TMS/TDI into the icetap JTAG TAP/register chain and captures TDO.

---
 rtl/icetap_jtag_master_if.sv | 27 ++
 rtl/icetap_jtag_master.sv | 184 ++++++++++++++++++
 tb/tb_icetap_jtag_master.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icetap_jtag_master_if.sv
// Command/response channel between a local controller and icetap_jtag_master.
// Latency: none, signal bundle only.
// Backpressure: cmd_ready gates commands; responses are a one-cycle pulse with no backpressure.
interface icetap_jtag_master_if #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_ir;
  logic [LEN_W-1:0]    cmd_len;
  logic [MAX_BITS-1:0] cmd_tdi_data;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_tdo_data;

  // Controller side: offers commands, receives captured TDO.
  modport master (
    output cmd_valid, cmd_ir, cmd_len, cmd_tdi_data,
    input  cmd_ready, rsp_valid, rsp_tdo_data
  );

  // JTAG master side: accepts commands, returns captured TDO.
  modport slave (
    input  cmd_valid, cmd_ir, cmd_len, cmd_tdi_data,
    output cmd_ready, rsp_valid, rsp_tdo_data
  );
endinterface

// File: rtl/icetap_jtag_master.sv
// On-chip JTAG initiator: walks the TAP through IR/DR scans or a TMS reset and returns captured TDO.
// Latency: 2*CLK_DIV*(hdr+len+2) scan_clk cycles from accept to rsp_valid (hdr 3 DR / 4 IR); 12*CLK_DIV for TAP reset.
// Backpressure: cmd_ready only while idle, busy commands are ignored; rsp_valid is a single unstalled pulse.
module icetap_jtag_master #(
  parameter int MAX_BITS = 64,
  parameter int CLK_DIV  = 2,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                 scan_clk_i,
  input  logic                 scan_reset_i,
  icetap_jtag_master_if.slave  cmd_if,
  output logic                 tck_o,
  output logic                 tms_o,
  output logic                 tdi_o,
  input  logic                 tdo_i
);

  localparam int SLOT_W = $clog2(2 * CLK_DIV);
  localparam int IDX_W  = $clog2(MAX_BITS);
  // The counter also walks the 6 TRST slots, so it needs at least 3 bits.
  localparam int CNT_W  = (LEN_W > 3) ? LEN_W : 3;

  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(2 * CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_RISE   = SLOT_W'(CLK_DIV);
  localparam logic [SLOT_W-1:0] SLOT_SAMPLE = SLOT_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN     = LEN_W'(MAX_BITS);
  localparam logic [CNT_W-1:0]  TRST_LAST   = CNT_W'(5);

  typedef enum logic [2:0] {
    S_TRST,
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ir_q, ir_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [MAX_BITS-1:0] rsp_q, rsp_d;
  logic                cmd_rst_q, cmd_rst_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;

  logic [LEN_W-1:0]    len_clamped;
  logic [CNT_W-1:0]    hdr_last;
  logic [CNT_W-1:0]    len_last;
  logic                new_slot;

  assign len_clamped = (cmd_if.cmd_len > MAX_LEN) ? MAX_LEN : cmd_if.cmd_len;
  assign hdr_last    = ir_q ? CNT_W'(3) : CNT_W'(2);
  assign len_last    = CNT_W'(len_q) - CNT_W'(1);

  assign cmd_if.cmd_ready    = (state_q == S_IDLE);
  assign cmd_if.rsp_valid    = (state_q == S_DONE);
  assign cmd_if.rsp_tdo_data = rsp_q;
  assign tck_o               = tck_q;
  assign tms_o               = tms_q;
  assign tdi_o               = tdi_q;

  // Next state: slot timing, phase sequencing, TDO capture and the tms/tdi value of each new slot.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    ir_d      = ir_q;
    len_d     = len_q;
    data_d    = data_q;
    rsp_d     = rsp_q;
    cmd_rst_d = cmd_rst_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    new_slot  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tms_d  = 1'b0;
        tdi_d  = 1'b0;
        slot_d = '0;
        cnt_d  = '0;
        if (cmd_if.cmd_valid) begin
          ir_d      = cmd_if.cmd_ir;
          len_d     = len_clamped;
          data_d    = cmd_if.cmd_tdi_data;
          rsp_d     = '0;
          cmd_rst_d = (len_clamped == '0);
          state_d   = (len_clamped == '0) ? S_TRST : S_HDR;
          new_slot  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
        slot_d  = '0;
      end
      default: begin
        // TDO as it stands at the end of the low phase, i.e. the edge where tck rises.
        if (state_q == S_SHIFT && slot_q == SLOT_SAMPLE) begin
          rsp_d[cnt_q[IDX_W-1:0]] = tdo_i;
        end
        if (slot_q == SLOT_LAST) begin
          slot_d   = '0;
          cnt_d    = cnt_q + CNT_W'(1);
          new_slot = 1'b1;
          case (state_q)
            S_TRST: if (cnt_q == TRST_LAST) begin
              cnt_d   = '0;
              state_d = cmd_rst_q ? S_DONE : S_IDLE;
            end
            S_HDR: if (cnt_q == hdr_last) begin
              cnt_d   = '0;
              state_d = S_SHIFT;
            end
            S_SHIFT: if (cnt_q == len_last) begin
              cnt_d   = '0;
              state_d = S_TAIL;
            end
            S_TAIL: if (cnt_q == CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end
            default: ;
          endcase
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
    endcase

    // tms/tdi change only as a slot begins (tck low) and hold for the whole slot.
    if (new_slot) begin
      tms_d = 1'b0;
      tdi_d = 1'b0;
      case (state_d)
        S_TRST:  tms_d = (cnt_d < TRST_LAST);
        S_HDR:   tms_d = (cnt_d == '0) || (ir_d && cnt_d == CNT_W'(1));
        S_SHIFT: begin
          tms_d = (cnt_d == CNT_W'(len_d) - CNT_W'(1));
          tdi_d = data_d[cnt_d[IDX_W-1:0]];
        end
        S_TAIL:  tms_d = (cnt_d == '0);
        default: ;
      endcase
    end

    tck_d = (slot_d >= SLOT_RISE);
  end

  // State register; reset restarts the TMS reset sequence and drops any scan in flight.
  always_ff @(posedge scan_clk_i) begin
    if (scan_reset_i) begin
      state_q   <= S_TRST;
      slot_q    <= '0;
      cnt_q     <= '0;
      ir_q      <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      cmd_rst_q <= 1'b0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      len_q     <= len_d;
      data_q    <= data_d;
      rsp_q     <= rsp_d;
      cmd_rst_q <= cmd_rst_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
    end
  end

endmodule

// File: tb/tb_icetap_jtag_master.sv
// Bench for icetap_jtag_master: a behavioural JTAG TAP target plus directed and random scans.
// Latency: checks accept-to-rsp_valid cycle counts against the scan length formula.
// Backpressure: exercises cmd_valid held high while busy and reset mid-scan.
module tb_icetap_jtag_master;

  localparam int MAX_BITS = 64;
  localparam int CLK_DIV  = 2;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck, tms, tdi;
  logic tdo = 1'b0;

  icetap_jtag_master_if #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) cmd_if();

  icetap_jtag_master #(.MAX_BITS(MAX_BITS), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .scan_clk_i   (clk),
    .scan_reset_i (rst),
    .cmd_if       (cmd_if),
    .tck_o        (tck),
    .tms_o        (tms),
    .tdi_o        (tdi),
    .tdo_i        (tdo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural TAP target ----------------
  typedef enum int {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e        tap = TLR;
  logic [63:0] dr_val = '0, dr_sh = '0, ir_val = '0, ir_sh = '0;
  int          dr_len = 8, ir_len = 4;
  int          n_shift = 0, tck_rises = 0, tlr_seen = 0;
  bit          tms_log[$];

  function automatic tap_e tap_next(input tap_e s, input logic t);
    case (s)
      TLR:     return t ? TLR    : RTI;
      RTI:     return t ? SEL_DR : RTI;
      SEL_DR:  return t ? SEL_IR : CAP_DR;
      CAP_DR:  return t ? EX1_DR : SH_DR;
      SH_DR:   return t ? EX1_DR : SH_DR;
      EX1_DR:  return t ? UPD_DR : PA_DR;
      PA_DR:   return t ? EX2_DR : PA_DR;
      EX2_DR:  return t ? UPD_DR : SH_DR;
      UPD_DR:  return t ? SEL_DR : RTI;
      SEL_IR:  return t ? TLR    : CAP_IR;
      CAP_IR:  return t ? EX1_IR : SH_IR;
      SH_IR:   return t ? EX1_IR : SH_IR;
      EX1_IR:  return t ? UPD_IR : PA_IR;
      PA_IR:   return t ? EX2_IR : PA_IR;
      EX2_IR:  return t ? UPD_IR : SH_IR;
      UPD_IR:  return t ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap)
      TLR:    tlr_seen++;
      CAP_DR: dr_sh = dr_val;
      SH_DR:  begin dr_sh = (dr_sh >> 1) | (64'(tdi) << (dr_len - 1)); n_shift++; end
      UPD_DR: dr_val = dr_sh;
      CAP_IR: ir_sh = ir_val;
      SH_IR:  begin ir_sh = (ir_sh >> 1) | (64'(tdi) << (ir_len - 1)); n_shift++; end
      UPD_IR: ir_val = ir_sh;
      default: ;
    endcase
    tck_rises++;
    tms_log.push_back(tms);
    tap = tap_next(tap, tms);
  end

  always @(negedge tck) begin
    tdo = (tap == SH_DR) ? dr_sh[0] : (tap == SH_IR) ? ir_sh[0] : 1'b0;
  end

  // ---------------- protocol monitors ----------------
  int   acc_cnt = 0, rsp_cnt = 0, stab_viol = 0;
  logic prev_tms = 1'b1, prev_tdi = 1'b0;

  always @(posedge clk) begin
    if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) acc_cnt++;
    if (!rst && cmd_if.rsp_valid) rsp_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && tck === 1'b1 && (tms !== prev_tms || tdi !== prev_tdi)) stab_viol++;
    prev_tms = tms;
    prev_tdi = tdi;
  end

  // ---------------- reference rules ----------------
  function automatic logic [63:0] mask64(input int l);
    logic [63:0] one = 64'd1;
    return (l >= 64) ? '1 : ((one << l) - 64'd1);
  endfunction
  function automatic int clampl(input int l);
    return (l > MAX_BITS) ? MAX_BITS : l;
  endfunction
  function automatic int ref_cycles(input bit ir, input int l);
    return 2 * CLK_DIV * ((l == 0) ? 6 : ((ir ? 4 : 3) + clampl(l) + 2));
  endfunction
  function automatic logic [63:0] ref_rsp(input int l, input logic [63:0] pre);
    return (l == 0) ? 64'd0 : (pre & mask64(clampl(l)));
  endfunction
  function automatic logic [63:0] ref_reg(input int l, input logic [63:0] d, input logic [63:0] pre);
    return (l == 0) ? pre : (d & mask64(clampl(l)));
  endfunction
  // Count positions where the logged TMS stream differs from the expected TAP walk.
  function automatic int tms_mismatch(input bit ir, input int l);
    bit e[$];
    int m = 0;
    if (l == 0) begin
      for (int i = 0; i < 5; i++) e.push_back(1'b1);
      e.push_back(1'b0);
    end else begin
      e.push_back(1'b1);
      if (ir) e.push_back(1'b1);
      e.push_back(1'b0);
      e.push_back(1'b0);
      for (int i = 0; i < clampl(l); i++) e.push_back(i == clampl(l) - 1);
      e.push_back(1'b1);
      e.push_back(1'b0);
    end
    if (e.size() != tms_log.size()) return 1000 + tms_log.size();
    foreach (e[i]) if (e[i] != tms_log[i]) m++;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit ir, input int len, input logic [63:0] data, input bit hold);
    int guard = 0;
    @(negedge clk);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_ir       = ir;
    cmd_if.cmd_len      = LEN_W'(len);
    cmd_if.cmd_tdi_data = data;
    while (cmd_if.cmd_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("accept_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    tck_rises = 0;
    n_shift   = 0;
    tms_log.delete();
    #1;
    if (!hold) cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cmd_if.rsp_valid !== 1'b1 && n < 5000);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cmd_if.cmd_ready !== 1'b1 && n < 5000);
  endtask

  typedef struct {
    bit          ir;
    int          len;
    logic [63:0] data;
    logic [63:0] preload;
    bit          hold;
    logic [63:0] exp_rsp;
    logic [63:0] exp_reg;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ml, acc0, r0, t0;
    logic [63:0] d16;

    vecs[0] = '{0, 8,  64'hA5, 64'h3C, 0, 64'h3C, 64'hA5, 52};
    vecs[1] = '{1, 4,  64'h9,  64'h6,  0, 64'h6,  64'h9,  40};
    vecs[2] = '{0, 0,  64'hFFFF, 64'h1234, 0, 64'h0, 64'h1234, 24};
    vecs[3] = '{0, 69, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 1,
                64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_0123_4567, 276};
    vecs[4] = '{1, 1,  64'h1, 64'h0, 0, 64'h0, 64'h1, 28};
    vecs[5] = '{0, 64, 64'h0123_4567_89AB_CDEF, 64'hF0F0_0F0F_A5A5_5A5A, 0,
                64'hF0F0_0F0F_A5A5_5A5A, 64'h0123_4567_89AB_CDEF, 276};
    for (int i = 6; i < 14; i++) begin
      vecs[i].ir      = 1'($urandom_range(0, 1));
      vecs[i].len     = int'($urandom_range(0, 70));
      vecs[i].data    = {$urandom(), $urandom()};
      vecs[i].preload = {$urandom(), $urandom()};
      vecs[i].hold    = 1'b0;
      vecs[i].exp_rsp    = ref_rsp(vecs[i].len, vecs[i].preload);
      vecs[i].exp_reg    = ref_reg(vecs[i].len, vecs[i].data, vecs[i].preload);
      vecs[i].exp_cycles = ref_cycles(vecs[i].ir, vecs[i].len);
    end

    // Reset values and the power-up TMS reset walk.
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_ir       = 1'b0;
    cmd_if.cmd_len      = '0;
    cmd_if.cmd_tdi_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_if.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(cmd_if.rsp_valid), 64'd0);
    check("rst_rsp_data", cmd_if.rsp_tdo_data, 64'd0);
    tms_log.delete();
    tck_rises = 0;
    rst = 1'b0;
    wait_ready(n);
    check("trst_ready_cycle", 64'(n), 64'd24);
    check("trst_tck_pulses", 64'(tck_rises), 64'd6);
    check("trst_tms_seq", 64'(tms_mismatch(0, 0)), 64'd0);
    check("trst_no_rsp", 64'(rsp_cnt), 64'd0);
    check("trst_tap_rti", 64'(tap), 64'(RTI));

    // Table of scans, each scored against the TAP model and the timing formula.
    for (int i = 0; i < 14; i++) begin
      ml = (vecs[i].len == 0) ? 64 : clampl(vecs[i].len);
      if (vecs[i].ir) begin
        ir_len = ml;
        ir_val = vecs[i].preload & mask64(ml);
      end else begin
        dr_len = ml;
        dr_val = vecs[i].preload & mask64(ml);
      end
      acc0 = acc_cnt;
      t0   = tlr_seen;
      issue(vecs[i].ir, vecs[i].len, vecs[i].data, vecs[i].hold);
      wait_rsp(n);
      check($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].exp_cycles));
      check($sformatf("v%0d_rsp_data", i), cmd_if.rsp_tdo_data, vecs[i].exp_rsp);
      check($sformatf("v%0d_tck_pulses", i), 64'(tck_rises),
            64'((vecs[i].len == 0) ? 6 : ((vecs[i].ir ? 4 : 3) + clampl(vecs[i].len) + 2)));
      check($sformatf("v%0d_shift_slots", i), 64'(n_shift), 64'((vecs[i].len == 0) ? 0 : clampl(vecs[i].len)));
      check($sformatf("v%0d_tms_seq", i), 64'(tms_mismatch(vecs[i].ir, vecs[i].len)), 64'd0);
      check($sformatf("v%0d_tap_rti", i), 64'(tap), 64'(RTI));
      check($sformatf("v%0d_target_reg", i), vecs[i].ir ? ir_val : dr_val, vecs[i].exp_reg);
      if (vecs[i].len == 0) check($sformatf("v%0d_saw_tlr", i), 64'(tlr_seen > t0), 64'd1);
      if (!vecs[i].hold) begin
        @(posedge clk);
        #1;
        check($sformatf("v%0d_rsp_pulse_1cyc", i), 64'(cmd_if.rsp_valid), 64'd0);
        check($sformatf("v%0d_ready_after", i), 64'(cmd_if.cmd_ready), 64'd1);
        check($sformatf("v%0d_rsp_hold", i), cmd_if.rsp_tdo_data, vecs[i].exp_rsp);
      end else begin
        // cmd_valid stayed high for the whole scan: exactly one accept so far, the next one right after DONE.
        check("hold_single_accept", 64'(acc_cnt - acc0), 64'd1);
        @(posedge clk);
        #1;
        check("hold_idle_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("hold_no_early_accept", 64'(acc_cnt - acc0), 64'd1);
        @(posedge clk);
        tck_rises = 0;
        n_shift   = 0;
        tms_log.delete();
        #1;
        check("hold_second_accept", 64'(acc_cnt - acc0), 64'd2);
        check("hold_busy", 64'(cmd_if.cmd_ready), 64'd0);
        cmd_if.cmd_valid = 1'b0;
        wait_rsp(n);
        check("hold2_latency", 64'(n), 64'(vecs[i].exp_cycles));
        check("hold2_rsp_data", cmd_if.rsp_tdo_data, vecs[i].exp_reg);
        check("hold2_tck_pulses", 64'(tck_rises), 64'd69);
      end
    end

    // Reset during shift bit 3 of a 16-bit DR scan.
    d16    = 64'($urandom_range(0, 65535));
    dr_len = 16;
    dr_val = 64'h0000_0000_0000_BEEF;
    issue(0, 16, d16, 0);
    r0 = rsp_cnt;
    repeat (25) @(posedge clk);
    #1;
    check("abort_in_bit3", 64'(n_shift), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tck", 64'(tck), 64'd0);
    check("abort_tms", 64'(tms), 64'd1);
    check("abort_ready", 64'(cmd_if.cmd_ready), 64'd0);
    tms_log.delete();
    tck_rises = 0;
    rst = 1'b0;
    wait_ready(n);
    check("abort_ready_cycle", 64'(n), 64'd24);
    check("abort_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    check("abort_tms_seq", 64'(tms_mismatch(0, 0)), 64'd0);
    check("abort_tap_rti", 64'(tap), 64'(RTI));

    check("tms_tdi_stable_in_slot", 64'(stab_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
